// File: rtl/game_ctrl_pkg.sv
// Shared state encoding, constants and width helpers for the player state controller.
package game_ctrl_pkg;

  typedef enum logic [1:0] {ALIVE, HURT, DEAD} slot_state_e;

  localparam int unsigned REVIVE_FRAMES = 300;

  function automatic int unsigned LIFE_UP_IDX(input int unsigned num_powerups);
    return num_powerups - 1;
  endfunction

  // Bits needed to hold every value 0..max_val.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/player_slot.sv
// One player slot: event latches, ALIVE/HURT/DEAD FSM, hit-invulnerability counter and power-up timers.
// Optional PLAYER_REVIVE_EN adds a dead-time counter that revives the slot while another slot is alive.
module player_slot
  import game_ctrl_pkg::*;
#(
  parameter int unsigned MAX_LIFE          = 3,
  parameter int unsigned NUM_POWERUPS      = 4,
  parameter int unsigned POWERUP_TIME      = 1000,
  parameter int unsigned HIT_INVULN_FRAMES = 64,
  parameter int unsigned LIFE_W            = cnt_w(MAX_LIFE),
  parameter int unsigned PU_W              = idx_w(NUM_POWERUPS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    startOfFrame,
  input  logic                    out_of_time,
  input  logic                    invincible_i,
  input  logic                    others_active_i,
  input  logic                    hit_pulse_i,
  input  logic                    pickup_hit_i,
  input  logic [PU_W-1:0]         pickup_type_i,
  output logic [LIFE_W-1:0]       lives_o,
  output logic                    active_o,
  output logic                    red_o,
  output logic [NUM_POWERUPS-2:0] powerup_o
);

  localparam int unsigned NUM_TMR = LIFE_UP_IDX(NUM_POWERUPS);
  localparam int unsigned TMR_W   = cnt_w(POWERUP_TIME);
  localparam int unsigned RED_W   = cnt_w(HIT_INVULN_FRAMES);

  slot_state_e                    state_q;
  logic [LIFE_W-1:0]              lives_q;
  logic [RED_W-1:0]               red_q;
  logic [NUM_TMR-1:0][TMR_W-1:0]  tmr_q;
  logic                           hit_pend_q;
  logic                           pu_pend_q;
  logic [PU_W-1:0]                type_q;

  logic                           hit_ok;
  logic                           pu_d;
  logic                           lifeup_d;
  logic [PU_W-1:0]                type_d;
  logic [LIFE_W-1:0]              lives_up;
  logic [NUM_TMR-1:0][TMR_W-1:0]  tmr_d;
  logic                           revive;

  // A pulse in the frame-edge cycle itself is folded into this frame's update.
  always_comb begin
    tmr_d    = tmr_q;
    hit_ok   = (hit_pend_q | hit_pulse_i) & ~invincible_i;
    pu_d     = pu_pend_q | pickup_hit_i;
    type_d   = pickup_hit_i ? pickup_type_i : type_q;
    lifeup_d = pu_d && (type_d == PU_W'(NUM_TMR));
    lives_up = (lifeup_d && lives_q != LIFE_W'(MAX_LIFE)) ? lives_q + LIFE_W'(1) : lives_q;
    for (int unsigned t = 0; t < NUM_TMR; t++) begin
      if (pu_d && type_d == PU_W'(t))
        tmr_d[t] = TMR_W'(POWERUP_TIME);
      else if (tmr_q[t] != '0)
        tmr_d[t] = tmr_q[t] - TMR_W'(1);
    end
  end

`ifdef PLAYER_REVIVE_EN
  localparam int unsigned REV_W = cnt_w(REVIVE_FRAMES);
  logic [REV_W-1:0] rev_cnt_q;
  logic             oot_seen_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rev_cnt_q  <= '0;
      oot_seen_q <= 1'b0;
    end else if (startOfFrame) begin
      if (out_of_time) oot_seen_q <= 1'b1;
      if (state_q != DEAD)
        rev_cnt_q <= '0;
      else if (rev_cnt_q != REV_W'(REVIVE_FRAMES - 1))
        rev_cnt_q <= rev_cnt_q + REV_W'(1);
    end
  end

  assign revive = (state_q == DEAD) && (rev_cnt_q == REV_W'(REVIVE_FRAMES - 1)) &&
                  others_active_i && !oot_seen_q && !out_of_time;
`else
  logic unused_others_active;
  assign unused_others_active = others_active_i;
  assign revive = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ALIVE;
      lives_q    <= LIFE_W'(MAX_LIFE);
      red_q      <= '0;
      tmr_q      <= '0;
      hit_pend_q <= 1'b0;
      pu_pend_q  <= 1'b0;
      type_q     <= '0;
    end else if (!startOfFrame) begin
      if (hit_pulse_i) hit_pend_q <= 1'b1;
      if (pickup_hit_i) begin
        pu_pend_q <= 1'b1;
        type_q    <= pickup_type_i;
      end
    end else begin
      hit_pend_q <= 1'b0;
      pu_pend_q  <= 1'b0;
      if (state_q == DEAD) begin
        if (revive) begin
          state_q <= HURT;
          lives_q <= LIFE_W'(1);
          red_q   <= RED_W'(HIT_INVULN_FRAMES);
        end
      end else if (out_of_time) begin
        state_q <= DEAD;
        red_q   <= '0;
        tmr_q   <= '0;
      end else if (hit_ok && lives_q == LIFE_W'(1)) begin
        state_q <= DEAD;
        lives_q <= '0;
        red_q   <= '0;
        tmr_q   <= '0;
      end else begin
        tmr_q <= tmr_d;
        if (hit_ok) begin
          // Hit then life-up in one frame nets out to the current count.
          state_q <= HURT;
          red_q   <= RED_W'(HIT_INVULN_FRAMES);
          lives_q <= lifeup_d ? lives_q : lives_q - LIFE_W'(1);
        end else begin
          lives_q <= lives_up;
          if (state_q == HURT) begin
            red_q <= red_q - RED_W'(1);
            if (red_q == RED_W'(1)) state_q <= ALIVE;
          end
        end
      end
    end
  end

  always_comb begin
    powerup_o = '0;
    for (int unsigned t = 0; t < NUM_TMR; t++) powerup_o[t] = (tmr_q[t] != '0);
  end

  assign lives_o  = lives_q;
  assign active_o = (state_q != DEAD);
  assign red_o    = (state_q == HURT);

endmodule

// File: rtl/player_state_ctrl.sv
// Multi-player life / invulnerability / power-up controller: one player_slot per player,
// invincibility fan-in and game-over reduction. PLAYER_REVIVE_EN enables slot revival.
module player_state_ctrl
  import game_ctrl_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS       = 2,
  parameter int unsigned MAX_LIFE          = 3,
  parameter int unsigned NUM_POWERUPS      = 4,
  parameter int unsigned POWERUP_TIME      = 1000,
  parameter int unsigned HIT_INVULN_FRAMES = 64,
  localparam int unsigned LIFE_W           = cnt_w(MAX_LIFE),
  localparam int unsigned PU_W             = idx_w(NUM_POWERUPS)
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     startOfFrame,
  input  logic                                     god_mode,
  input  logic                                     out_of_time,
  input  logic [NUM_PLAYERS-1:0]                   hit_pulse,
  input  logic [NUM_PLAYERS-1:0]                   pickup_hit,
  input  logic [NUM_PLAYERS-1:0][PU_W-1:0]         pickup_type,
  output logic [NUM_PLAYERS-1:0][LIFE_W-1:0]       lives,
  output logic [NUM_PLAYERS-1:0]                   player_active,
  output logic [NUM_PLAYERS-1:0]                   player_red,
  output logic [NUM_PLAYERS-1:0][NUM_POWERUPS-2:0] powerup_active,
  output logic [NUM_PLAYERS-1:0]                   invincible,
  output logic                                     game_over
);

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_slot
    logic others_active;

    assign others_active = |(player_active & ~(NUM_PLAYERS'(1) << p));
    assign invincible[p] = god_mode | player_red[p] | powerup_active[p][0];

    player_slot #(
      .MAX_LIFE          (MAX_LIFE),
      .NUM_POWERUPS      (NUM_POWERUPS),
      .POWERUP_TIME      (POWERUP_TIME),
      .HIT_INVULN_FRAMES (HIT_INVULN_FRAMES),
      .LIFE_W            (LIFE_W),
      .PU_W              (PU_W)
    ) u_slot (
      .clk             (clk),
      .reset           (reset),
      .startOfFrame    (startOfFrame),
      .out_of_time     (out_of_time),
      .invincible_i    (invincible[p]),
      .others_active_i (others_active),
      .hit_pulse_i     (hit_pulse[p]),
      .pickup_hit_i    (pickup_hit[p]),
      .pickup_type_i   (pickup_type[p]),
      .lives_o         (lives[p]),
      .active_o        (player_active[p]),
      .red_o           (player_red[p]),
      .powerup_o       (powerup_active[p])
    );
  end

  assign game_over = ~|player_active;

endmodule

// File: doc/player_state_ctrl.md
Name: player_state_ctrl

Overview:
- Parametrised successor to the single-player life/power-up logic in the game controller.
- Tracks lives, hit invulnerability, death and per-type timed power-ups for NUM_PLAYERS independent players.
- Event pulses may arrive in any cycle. They are latched, then applied once per frame on startOfFrame.
- Feeds HUD hearts, player colouring/shield bitmaps, shot cooldown selection and game-over logic.

Parameters:
- NUM_PLAYERS, 2, number of player slots.
- MAX_LIFE, 3, lives at reset and life cap; LIFE_W = $clog2(MAX_LIFE+1).
- NUM_POWERUPS, 4, power-up types; index NUM_POWERUPS-1 is instant life-up; PU_W = $clog2(NUM_POWERUPS).
- POWERUP_TIME, 1000, frames a timed power-up lasts; TMR_W = $clog2(POWERUP_TIME+1).
- HIT_INVULN_FRAMES, 64, post-hit invulnerability frames.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- startOfFrame  in  1  one-cycle pulse per frame (30 Hz)
- god_mode  in  1  global invincibility cheat
- out_of_time  in  1  level timer expired
- hit_pulse  in  NUM_PLAYERS  per-player hit pulse, any cycle
- pickup_hit  in  NUM_PLAYERS  per-player pickup pulse, any cycle
- pickup_type  in  NUM_PLAYERS x PU_W  type, valid with pickup_hit
- lives  out  NUM_PLAYERS x LIFE_W  remaining lives
- player_active  out  NUM_PLAYERS  player alive
- player_red  out  NUM_PLAYERS  in post-hit invulnerability
- powerup_active  out  NUM_PLAYERS x (NUM_POWERUPS-1)  timed power-up flags
- invincible  out  NUM_PLAYERS  hits currently ignored
- game_over  out  1  no player active

Behaviour:
- Reset, immediate and asynchronous, from any state: lives=MAX_LIFE, player_active=all 1, player_red=0, powerup_active=0, all timers=0, all pending flags=0, game_over=0.
- Per-slot FSM states: ALIVE, HURT, DEAD.
- Latching, in any cycle:
  - hit_pulse sets hit_pend.
  - pickup_hit sets pu_pend and captures pickup_type; a later pickup before the frame overwrites the captured type.
  - A pulse coincident with startOfFrame is applied in that same frame.
  - Pending flags clear on every startOfFrame cycle.
- All state updates happen only on the clk edge where startOfFrame=1. Outputs change one clk after that edge.
- Invincibility check uses pre-update state: invincible = god_mode | (state==HURT) | powerup_active[0].
- Hit, with hit_pend set and not invincible:
  - lives>1: lives-1, ALIVE/HURT -> HURT, red counter loaded with HIT_INVULN_FRAMES.
  - lives==1: lives=0, -> DEAD.
- HURT: red counter decrements each frame; at 1 -> ALIVE on that frame. player_red=(state==HURT).
- Pickup, type t < NUM_POWERUPS-1: powerup_active[t]=1, timer[t]=POWERUP_TIME. Re-pickup of an active type reloads its timer; no accumulation.
- Pickup, type NUM_POWERUPS-1: lives+1, saturating at MAX_LIFE. No flag is set.
- Same frame hit and life-up: net lives = min(MAX_LIFE, lives-1+1). A life-up never cancels death when lives==1 was hit; death wins.
- Each timer decrements per frame. When a timer reaches 0, its flag clears on that same frame edge. Timers are independent per type and per player.
- DEAD is absorbing until reset:
  - Pending events are discarded.
  - Timers and flags clear.
  - player_active=0.
- out_of_time=1 on a frame edge: all slots -> DEAD, lives unchanged.
- game_over = ~|player_active, combinational from registered state.

Optional Feature:
- Macro PLAYER_REVIVE_EN.
- Defined:
  - A DEAD slot counts REVIVE_FRAMES (package constant, 300) frames.
  - It then returns to HURT with lives=1 and the red counter loaded, but only if another slot is active at that frame.
  - If all slots are DEAD, or out_of_time has fired since reset, there is no revive and game_over holds.
- Undefined: DEAD is absorbing and the revive counter is absent.

Decomposition:
- Package game_ctrl_pkg: state enum (ALIVE/HURT/DEAD), LIFE_UP_IDX function (NUM_POWERUPS-1), REVIVE_FRAMES, width helper functions.
- Sub-module player_slot: one FSM, pending latches, red counter and timer array. Generated NUM_PLAYERS times.
- Top level: invincibility fan-in and game_over reduction.

Test Plan:
- Reset mid-HURT with a power-up active -> next cycle lives=3, player_red=0, powerup_active=0, game_over=0.
- Hit on P0 mid-frame, then startOfFrame -> lives[0]=2, player_red[0]=1 for 64 frames then 0; second hit at frame 10 ignored, lives stays 2.
- P1 pickup type 0; hit at frame 500 ignored. Re-pickup at frame 900 -> flag stays 1 until frame 1900 and drops exactly there.
- P0 lives=3, life-up pickup -> stays 3. Lives=2, simultaneous hit+life-up -> 2. Lives=1, simultaneous -> DEAD, lives=0.
- Both players hit to 0 -> game_over=1 one clk after the frame edge. With PLAYER_REVIVE_EN, P0 dead and P1 alive -> P0 revives after 300 frames with lives=1.
- out_of_time with god_mode=1 -> all player_active=0, game_over=1, later hit/pickup pulses change nothing.
